// File: rtl/krnl_cam_result_accum_if.sv
// ---------------------------------------------------------------------------
// krnl_cam_result_accum_if
//   Streaming valid/ready bundle used on both sides of the CAM result
//   accumulator. W sets the payload width.
//
//   Signals:
//     TDATA  [W-1:0]  payload, driven by the master
//     TVALID          payload valid, driven by the master
//     TREADY          sink ready, driven by the slave
//   A beat transfers on a rising edge where TVALID and TREADY are both high.
// ---------------------------------------------------------------------------
interface krnl_cam_result_accum_if #(
  parameter int W = 520
);
  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/krnl_cam_result_accum.sv
// ---------------------------------------------------------------------------
// krnl_cam_result_accum
//   Consumes the CAM kernel's result stream, counts the set bits of each
//   word's match bitmap and accumulates them into a per-batch triangle count.
//   When the batch's LAST word has gone through the pipeline it emits
//   {word_count, triangle_count} toward the host-facing writer.
//
//   Parameters:
//     C_DATA_WIDTH  input word width, control byte in the top 8 bits
//     CAM_SIZE      bitmap bits in s.TDATA[CAM_SIZE-1:0]; must be a multiple
//                   of 32 and no larger than C_DATA_WIDTH-8
//     C_ACC_WIDTH   triangle accumulator width
//     C_WCNT_WIDTH  per-batch counted-word width
//
//   Ports:
//     ap_clk     clock, all logic on the rising edge
//     areset     synchronous active-high reset
//     s          slave stream, C_DATA_WIDTH-bit result words
//                (control byte: bit0 LAST, bit1 SKIP, bits 7:2 ignored)
//     m          master stream, {word_count, triangle_count}
//     batch_cnt  results accepted on m since reset (wraps at 2^32)
//
//   Pipeline: stage 1 registers 32-bit chunk popcounts, stage 2 registers
//   their sum, stage 3 accumulates and builds the result. A LAST word
//   accepted in cycle N shows m.TVALID in cycle N+3.
// ---------------------------------------------------------------------------
module krnl_cam_result_accum #(
  parameter int C_DATA_WIDTH = 520,
  parameter int CAM_SIZE     = 128,
  parameter int C_ACC_WIDTH  = 64,
  parameter int C_WCNT_WIDTH = 32
) (
  input  logic                           ap_clk,
  input  logic                           areset,
  krnl_cam_result_accum_if.slave         s,
  krnl_cam_result_accum_if.master        m,
  output logic [31:0]                    batch_cnt
);

  localparam int N_CHUNK = CAM_SIZE / 32;
  localparam int SUM_W   = $clog2(CAM_SIZE + 1);
  localparam int OUT_W   = C_ACC_WIDTH + C_WCNT_WIDTH;

  // Popcount of one 32-bit bitmap chunk; 6 bits holds the maximum of 32.
  function automatic logic [5:0] popcnt32(input logic [31:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(x[i]);
    end
    return c;
  endfunction

  logic [7:0]              ctl;
  logic                    is_last;
  logic                    is_skip;
  logic                    accept;

  logic [5:0]              chunk_cnt [N_CHUNK];
  logic                    v1;
  logic                    l1;

  logic [SUM_W-1:0]        sum_comb;
  logic [SUM_W-1:0]        sum2;
  logic                    v2;
  logic                    l2;

  logic [C_ACC_WIDTH-1:0]  acc;
  logic [C_ACC_WIDTH-1:0]  acc_next;
  logic [C_WCNT_WIDTH-1:0] wcnt;
  logic [C_WCNT_WIDTH-1:0] wcnt_next;
  logic [OUT_W-1:0]        m_data;
  logic                    m_valid;

  assign ctl     = s.TDATA[C_DATA_WIDTH-1 -: 8];
  assign is_last = ctl[0];
  assign is_skip = ctl[1];
  assign accept  = s.TVALID & s.TREADY;

  // The payload bits between the bitmap and the control byte, and the
  // reserved control bits, carry nothing this block uses.
  logic unused_ctl;
  assign unused_ctl = ^ctl[7:2];

  generate
    if (C_DATA_WIDTH - 8 > CAM_SIZE) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^s.TDATA[C_DATA_WIDTH-9:CAM_SIZE];
    end
  endgenerate

  // Input is held off from the moment a LAST word is accepted until its
  // result has been taken, so only one batch is ever past the input and
  // the single output register can never be overrun. Depends on
  // registered state and reset only, never on s.TVALID or m.TREADY.
  assign s.TREADY = ~(areset | l1 | l2 | m_valid);

  // Stage 1: chunk popcounts plus the count/close flags of the beat.
  // A SKIP word still closes the batch if it is LAST, it just adds nothing.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < N_CHUNK; i++) begin
        chunk_cnt[i] <= '0;
      end
    end else begin
      v1 <= accept & ~is_skip;
      l1 <= accept & is_last;
      for (int i = 0; i < N_CHUNK; i++) begin
        chunk_cnt[i] <= popcnt32(s.TDATA[i*32 +: 32]);
      end
    end
  end

  // Adder tree for the chunk counts, kept out of stage 1 for timing.
  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      sum_comb = sum_comb + SUM_W'(chunk_cnt[i]);
    end
  end

  // Stage 2: registered word popcount.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      sum2 <= '0;
      v2   <= 1'b0;
      l2   <= 1'b0;
    end else begin
      sum2 <= sum_comb;
      v2   <= v1;
      l2   <= l1;
    end
  end

  // Next accumulator values including the word now in stage 2; both wrap.
  always_comb begin
    acc_next  = acc;
    wcnt_next = wcnt;
    if (v2) begin
      acc_next  = acc + C_ACC_WIDTH'(sum2);
      wcnt_next = wcnt + C_WCNT_WIDTH'(1);
    end
  end

  // Stage 3: accumulate, and on the closing word publish the totals and
  // restart the batch. The output cannot be busy when l2 arrives because
  // the input was blocked, so the handshake clear and the load never clash.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      acc       <= '0;
      wcnt      <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      batch_cnt <= '0;
    end else begin
      if (m_valid && m.TREADY) begin
        m_valid   <= 1'b0;
        batch_cnt <= batch_cnt + 32'd1;
      end
      if (l2) begin
        m_data  <= {wcnt_next, acc_next};
        m_valid <= 1'b1;
        acc     <= '0;
        wcnt    <= '0;
      end else begin
        acc  <= acc_next;
        wcnt <= wcnt_next;
      end
    end
  end

  assign m.TDATA  = m_data;
  assign m.TVALID = m_valid;

endmodule

// File: tb/tb_krnl_cam_result_accum.sv
// ---------------------------------------------------------------------------
// tb_krnl_cam_result_accum
//   Bench for krnl_cam_result_accum. Two copies of the design see the same
//   input stream: one with the default 64-bit accumulator and one with an
//   8-bit accumulator so that accumulator wrap is reachable. Expected
//   results come from a batch-level model (bit counts summed per batch) and
//   are queued when the LAST word is accepted; independent monitors pop and
//   compare whenever a result transfers.
// ---------------------------------------------------------------------------
module tb_krnl_cam_result_accum;

  localparam int DW  = 520;
  localparam int CS  = 128;
  localparam int OW  = 96;
  localparam int OW8 = 40;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        m_ready;
  logic        rand_ready;
  logic [31:0] batch_cnt;
  logic [31:0] batch_cnt8;

  krnl_cam_result_accum_if #(.W(DW))  s  ();
  krnl_cam_result_accum_if #(.W(OW))  m  ();
  krnl_cam_result_accum_if #(.W(DW))  s8 ();
  krnl_cam_result_accum_if #(.W(OW8)) m8 ();

  always #5 ap_clk = ~ap_clk;

  // The narrow-accumulator copy mirrors the main input; its ready logic is
  // independent of accumulator width so it accepts the same beats.
  assign s8.TDATA  = s.TDATA;
  assign s8.TVALID = s.TVALID;
  assign m.TREADY  = m_ready;
  assign m8.TREADY = m_ready;

  krnl_cam_result_accum dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .s         (s),
    .m         (m),
    .batch_cnt (batch_cnt)
  );

  krnl_cam_result_accum #(.C_ACC_WIDTH(8)) dut8 (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .s         (s8),
    .m         (m8),
    .batch_cnt (batch_cnt8)
  );

  int                n_compared   = 0;
  int                n_mismatched = 0;
  logic [OW-1:0]     exp_q [$];
  logic [OW8-1:0]    exp8_q [$];
  longint unsigned   model_tri;
  int unsigned       model_wcnt;
  int unsigned       exp_batches;
  int unsigned       exp_batches8;
  int unsigned       cyc = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Build a word with random filler and reserved control bits, offer it
  // until accepted and fold it into the batch model on acceptance.
  task automatic applyStimulus(input logic [CS-1:0] bmap, input bit last,
                               input bit skip, output int waited);
    logic [543:0] t;
    logic [DW-1:0] w;
    logic [7:0] ctl;
    bit ok;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    w = t[DW-1:0];
    ctl = 8'($urandom);
    ctl[0] = last;
    ctl[1] = skip;
    w[CS-1:0] = bmap;
    w[DW-1 -: 8] = ctl;
    s.TDATA  = w;
    s.TVALID = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge ap_clk);
      if (s.TREADY === 1'b1) begin
        ok = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          checkOutput("accept_timeout", 0, 1);
          break;
        end
        @(posedge ap_clk); #1;
      end
    end
    if (ok) begin
      if (!skip) begin
        model_tri  += longint'($countones(bmap));
        model_wcnt += 1;
      end
      if (last) begin
        exp_q.push_back({model_wcnt[31:0], model_tri[63:0]});
        exp8_q.push_back({model_wcnt[31:0], 8'(model_tri % 256)});
        model_tri  = 0;
        model_wcnt = 0;
      end
      @(posedge ap_clk); #1;
    end
    s.TVALID = 1'b0;
  endtask

  // Monitor for the 64-bit copy.
  always @(negedge ap_clk) begin
    if (!areset && m.TVALID === 1'b1 && m.TREADY === 1'b1) begin
      checkOutput("batch_cnt", batch_cnt, exp_batches);
      checkOutput("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) checkOutput("result", m.TDATA, exp_q.pop_front());
      exp_batches++;
    end
  end

  // Monitor for the 8-bit-accumulator copy.
  always @(negedge ap_clk) begin
    if (!areset && m8.TVALID === 1'b1 && m8.TREADY === 1'b1) begin
      checkOutput("batch_cnt8", batch_cnt8, exp_batches8);
      checkOutput("result8_expected", exp8_q.size() != 0, 1);
      if (exp8_q.size() != 0) checkOutput("result8", m8.TDATA, exp8_q.pop_front());
      exp_batches8++;
    end
  end

  // Random output backpressure when enabled.
  initial begin
    forever begin
      @(posedge ap_clk); #1;
      if (rand_ready) m_ready = 1'($urandom);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    @(posedge ap_clk); #1;
    areset = 1'b1;
    s.TVALID = 1'b0;
    exp_q.delete();
    exp8_q.delete();
    model_tri = 0;
    model_wcnt = 0;
    exp_batches = 0;
    exp_batches8 = 0;
    @(negedge ap_clk);
    checkOutput("rst_ready_low", s.TREADY, 0);
    @(negedge ap_clk);
    checkOutput("rst_m_valid", m.TVALID, 0);
    checkOutput("rst_m_data", m.TDATA, 0);
    checkOutput("rst_batch_cnt", batch_cnt, 0);
    checkOutput("rst_m8_valid", m8.TVALID, 0);
    checkOutput("rst_m8_data", m8.TDATA, 0);
    checkOutput("rst_ready_still_low", s.TREADY, 0);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    @(negedge ap_clk);
    checkOutput("rst_ready_after_release", s.TREADY, 1);
    @(posedge ap_clk); #1;
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (m.TVALID !== 1'b1 && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput(name, m.TVALID, 1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 2000) begin
      @(posedge ap_clk); #1;
      n++;
    end
    checkOutput("drain_q", exp_q.size(), 0);
    checkOutput("drain_q8", exp8_q.size(), 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  int w;
  int wsum;
  int unsigned c0;
  bit t1_rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit t1_mv  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    m_ready    = 1'b1;
    rand_ready = 1'b0;
    s.TVALID   = 1'b0;
    s.TDATA    = '0;
    doReset();

    // Basic batch with exact latency and ready-gap timing.
    $display("[TB] basic batch");
    applyStimulus(128'hF, 0, 0, w);
    applyStimulus(128'hFF, 0, 0, w);
    applyStimulus(128'h0, 0, 0, w);
    applyStimulus({CS{1'b1}}, 1, 0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      checkOutput($sformatf("t1_ready_c%0d", k + 1), s.TREADY, t1_rdy[k]);
      checkOutput($sformatf("t1_mvalid_c%0d", k + 1), m.TVALID, t1_mv[k]);
      if (k == 2) checkOutput("t1_data", m.TDATA, {32'd4, 64'd140});
    end
    checkOutput("t1_batch_cnt", batch_cnt, 1);
    @(posedge ap_clk); #1;

    // Skipped middle word.
    $display("[TB] skip word");
    applyStimulus(128'h1, 0, 0, w);
    applyStimulus(128'hFFFF, 0, 1, w);
    applyStimulus(128'h1, 1, 0, w);
    waitDrain();

    // Output stall with upstream data waiting.
    $display("[TB] output stall");
    m_ready = 1'b0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, 0, w);
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1, 0, w);
    waitValid("t3_valid_seen");
    s.TDATA[DW-1 -: 8] = 8'h00;
    s.TVALID = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput("t3_hold_valid", m.TVALID, 1);
      if (exp_q.size() != 0) checkOutput("t3_hold_data", m.TDATA, exp_q[0]);
      checkOutput("t3_hold_ready", s.TREADY, 0);
      @(negedge ap_clk);
    end
    @(posedge ap_clk); #1;
    m_ready = 1'b1;
    applyStimulus(128'h7, 0, 0, w);
    checkOutput("t3_accept_delay", w, 1);
    applyStimulus(128'h3, 1, 0, w);
    waitDrain();

    // Long streaming batch at full rate.
    $display("[TB] long batch");
    wsum = 0;
    c0 = cyc;
    for (int k = 0; k < 1001; k++) begin
      applyStimulus({CS{1'b1}}, k == 1000, 0, w);
      wsum += w;
    end
    checkOutput("t4_stall_cycles", wsum, 0);
    checkOutput("t4_cycles", cyc - c0, 1001);
    waitDrain();

    // Accumulator wrap on the 8-bit copy.
    $display("[TB] accumulator wrap");
    for (int k = 0; k < 3; k++) applyStimulus({CS{1'b1}}, k == 2, 0, w);
    waitDrain();

    // Empty batch.
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1, 1, w);
    waitDrain();

    // Reset mid-batch, then with a result pending.
    $display("[TB] reset cases");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, 0, w);
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, 0, w);
    doReset();
    m_ready = 1'b0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1, 0, w);
    waitValid("t6_valid_seen");
    doReset();
    m_ready = 1'b1;
    applyStimulus(128'h3, 1, 0, w);
    waitDrain();
    checkOutput("t6_batch_cnt", batch_cnt, 1);

    // Random batches under random backpressure.
    $display("[TB] random batches");
    rand_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        logic [CS-1:0] bm;
        int sel;
        sel = $urandom_range(0, 9);
        bm = {$urandom, $urandom, $urandom, $urandom};
        if (sel == 0) bm = '0;
        if (sel == 1) bm = {CS{1'b1}};
        applyStimulus(bm, k == len - 1, $urandom_range(0, 3) == 0, w);
      end
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    waitDrain();
    checkOutput("final_batch_cnt", batch_cnt, exp_batches);
    checkOutput("final_batch_cnt8", batch_cnt8, exp_batches8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/krnl_cam_result_accum.md
Name: krnl_cam_result_accum

Overview:
- Downstream consumer of the CAM kernel's 520-bit result stream (p1).
- Each result word carries a CAM match bitmap. The block pipelines a popcount of the bitmap and accumulates it into a 64-bit triangle count per batch.
- On the batch's last word it emits the total and the batch's word count on a result stream toward the host-facing writer.

Parameters:
- C_DATA_WIDTH, 520, input word width; top 8 bits are the control byte.
- CAM_SIZE, 128, number of valid bitmap bits in s_TDATA[CAM_SIZE-1:0]; must be a multiple of 32 and at most C_DATA_WIDTH-8.
- C_ACC_WIDTH, 64, accumulator and result-count width.
- C_WCNT_WIDTH, 32, per-batch accepted-word counter width.

Ports:
- ap_clk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- s_TDATA  input  C_DATA_WIDTH  result word from CAM kernel p1.
- s_TVALID  input  1  input valid.
- s_TREADY  output  1  input ready.
- m_TDATA  output  C_ACC_WIDTH+C_WCNT_WIDTH  {word_count, triangle_count}; triangle_count in the low C_ACC_WIDTH bits.
- m_TVALID  output  1  result valid.
- m_TREADY  input  1  result ready.
- batch_cnt  output  32  number of results accepted on m since reset.

Behaviour:
- Control byte ctl = s_TDATA[C_DATA_WIDTH-1 -: 8].
  - ctl[0] = LAST: final word of the batch.
  - ctl[1] = SKIP: word is not counted (e.g. update acknowledge).
  - ctl[7:2] are ignored.
- Beat accepted when s_TVALID & s_TREADY.
- Stage 1 (registered):
  - Splits bitmap[CAM_SIZE-1:0] into CAM_SIZE/32 chunks and registers each chunk's popcount (6 bits).
  - Registers v1 = accept & ~SKIP, l1 = accept & LAST.
- Stage 2 (registered):
  - Sums the chunk counts (width $clog2(CAM_SIZE+1)) and registers v2, l2.
- Stage 3 (accumulate):
  - If v2: acc <= acc + sum and wcnt <= wcnt + 1; both wrap modulo 2^width, with no saturation.
  - If l2: m_TDATA <= {wcnt_next, acc_next} (values including the current word); m_TVALID <= 1; acc <= 0; wcnt <= 0.
- Latency: a LAST beat accepted in cycle N gives m_TVALID high in cycle N+3.
- A LAST word with SKIP set still closes the batch; its bitmap is not added.
- s_TREADY:
  - Low while any of l1, l2 or m_TVALID is set; otherwise high.
  - Consequence: at most one batch is in flight past the input; no output overflow is possible.
  - s_TREADY is combinational from registered state only, never from s_TVALID or m_TREADY.
- Output handshake:
  - m_TVALID stays high and m_TDATA stays stable until m_TREADY.
  - m_TVALID clears in the cycle after acceptance.
  - batch_cnt increments on each m acceptance and wraps at 2^32.
- Back-to-back non-LAST beats are accepted at 1 per cycle indefinitely.
- An empty batch (a lone LAST+SKIP word) emits {0,0}.
- Reset (areset high, including mid-batch or with a result pending):
  - Next edge clears all pipeline valids, acc, wcnt, m_TVALID, m_TDATA and batch_cnt to 0.
  - s_TREADY is 0 while areset is high and 1 in the first cycle after release.
  - Partial batch and pending result are discarded.

Test Plan:
1. Reset, then 4 beats with bitmaps 0xF, 0xFF, 0x0, all-ones (128 bits), last flagged on 4th, m_TREADY=1 -> m_TDATA={4,140} at cycle of last+3; batch_cnt=1; s_TREADY low for exactly the 3 cycles l1, l2, m_TVALID.
2. Batch of 3 beats, middle beat SKIP with bitmap 0xFFFF, others 0x1 -> result {2,2}.
3. m_TREADY held low 10 cycles after result -> m_TVALID/m_TDATA stable, s_TREADY low throughout; upstream data with s_TVALID high not accepted until one cycle after the m handshake.
4. 1000 continuous non-LAST beats of all-ones then LAST -> 1001 accepts in 1001 cycles; result {1001,128128}.
5. Accumulator preloaded via 2^57 beats not feasible -> use a bench parameter override C_ACC_WIDTH=8: 3 beats of all-ones (128 each) -> triangle_count = 384 mod 256 = 128.
6. areset pulsed mid-batch (after 2 beats) and again with m_TVALID pending -> outputs zero next edge; a following 1-beat LAST batch bitmap 0x3 yields {1,2}, batch_cnt=1.
